// File: rtl/pll_clk_monitor_if.sv
// Status interface between the PLL clock monitor and its consumers.
// count_valid is a one-cycle qualifier for count/stuck; there is no ready, consumers must take it when it pulses.
interface pll_clk_monitor_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             clk_ok;
  logic             stuck;
  logic [1:0]       state_dbg;

  modport master (
    input  enable,
    output count,
    output count_valid,
    output clk_ok,
    output stuck,
    output state_dbg
  );

  modport slave (
    output enable,
    input  count,
    input  count_valid,
    input  clk_ok,
    input  stuck,
    input  state_dbg
  );
endinterface

// File: rtl/pll_clk_monitor.sv
// Counts mon_clk rising edges per gate window in the clkin domain and
// qualifies the frequency as good after enough consecutive in-band windows.
module pll_clk_monitor #(
  parameter int GATE_CYCLES  = 1000,
  parameter int EXPECT       = 50,
  parameter int TOL          = 2,
  parameter int GOOD_WINDOWS = 4,
  parameter int CNT_W        = 16
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              mon_clk,
  pll_clk_monitor_if.master bus
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W:0]    BAND_LO   = (EXPECT > TOL) ? (CNT_W+1)'(EXPECT - TOL) : '0;
  localparam logic [CNT_W:0]    BAND_HI   = (CNT_W+1)'(EXPECT + TOL);
  localparam logic [GOOD_W-1:0] GOOD_TGT  = GOOD_W'(GOOD_WINDOWS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nx;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  count_q;
  logic              count_valid_q;
  logic              clk_ok_q;
  logic              stuck_q;
  logic              s1, s2, s3;

  logic              edge_now;
  logic              terminal;
  logic              active;
  logic              close_win;
  logic [CNT_W:0]    sum_ext;
  logic [CNT_W-1:0]  result;
  logic              in_band;

  // s2 is the synchronized sample; s3 is its one-cycle-old copy for edge detection.
  assign edge_now  = s2 & ~s3;
  assign sum_ext   = {1'b0, edge_cnt} + (CNT_W+1)'(edge_now);
  assign result    = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
  assign terminal  = (gate_cnt == GATE_LAST);
  assign active    = (state != ST_IDLE) && bus.enable;
  assign close_win = active && terminal;
  assign in_band   = ({1'b0, result} >= BAND_LO) && ({1'b0, result} <= BAND_HI);

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      good_cnt <= '0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    case (state)
      ST_IDLE: begin
        good_nx = '0;
        if (bus.enable) state_nx = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (!bus.enable) begin
          state_nx = ST_IDLE;
          good_nx  = '0;
        end else if (terminal) begin
          if (in_band) begin
            good_nx = good_cnt + 1'b1;
            if (good_nx >= GOOD_TGT) state_nx = ST_LOCKED;
          end else begin
            good_nx = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (!bus.enable) begin
          state_nx = ST_IDLE;
          good_nx  = '0;
        end else if (terminal && !in_band) begin
          state_nx = ST_ACQUIRE;
          good_nx  = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        good_nx  = '0;
      end
    endcase
  end

  // clk_ok follows the next state so it changes together with the closing count_valid.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      s3            <= 1'b0;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      clk_ok_q      <= 1'b0;
      stuck_q       <= 1'b0;
    end else begin
      s1            <= mon_clk;
      s2            <= s1;
      s3            <= s2;
      count_valid_q <= close_win;
      clk_ok_q      <= (state_nx == ST_LOCKED);
      if (!active) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else if (terminal) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        count_q  <= result;
        stuck_q  <= (result == '0);
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= result;
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = count_valid_q;
  assign bus.clk_ok      = clk_ok_q;
  assign bus.stuck       = stuck_q;
  assign bus.state_dbg   = state;

endmodule
